imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//   Registered, parametrised immediate generator for the decode stage. Decodes every RV32I/RV64I
//   immediate format (I, S, B, U, J, CSR zimm) from a 32-bit instruction and sign-extends it to XLEN.
//   Sits between fetch and execute with a valid/ready handshake and a 2-entry skid buffer, so it
//   sustains one instruction per cycle under backpressure. Carries a TAG_W side-band tag (PC/ROB id).
// PARAMETERS
//   XLEN   32  immediate output width; legal values 32, 64
//   TAG_W  32  width of pass-through tag
// PORTS
//   clk          in   1      clock, rising edge
//   reset        in   1      asynchronous, active-high reset
//   flush        in   1      synchronous pipeline flush
//   in_valid     in   1      instruction valid
//   in_ready     out  1      block can accept this cycle
//   in_instr     in   32     instruction word
//   in_tag       in   TAG_W  side-band tag
//   out_valid    out  1      result valid
//   out_ready    in   1      consumer accepts result
//   out_imm      out  XLEN   sign/zero-extended immediate
//   out_fmt      out  3      0 NONE,1 I,2 S,3 B,4 U,5 J,6 Z(zimm)
//   out_tag      out  TAG_W  tag of result
// BEHAVIOUR
// - Reset: out_valid=0, out_imm=0, out_fmt=0, out_tag=0, skid empty, in_ready=1.
// - in_ready = !skid_valid (registered state, no combinational path from out_ready).
// - Accept when in_valid&&in_ready; result on out_* next cycle (latency 1). Transfer when out_valid&&out_ready.
// - Output reg empty or draining: new beat loads output reg. Output stalled: new beat goes to skid,
//   in_ready drops next cycle. Output draining with skid full: skid moves to output, skid empties.
// - Order strictly preserved; no beat dropped or duplicated.
// - flush: clears out_valid and skid_valid next edge; wins over simultaneous accept; data regs keep value.
// - Decode on instr[6:2] (instr[1:0] must be 2'b11, else NONE):
//     00000 LOAD, 00100 OP-IMM, 11001 JALR, 00011 MISC-MEM -> I: sext(instr[31:20])
//     00110 OP-IMM-32 -> I when XLEN=64, else NONE
//     01000 STORE -> S: sext({instr[31:25],instr[11:7]})
//     11000 BRANCH -> B: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0})
//     01101 LUI, 00101 AUIPC -> U: sext({instr[31:12],12'b0})
//     11011 JAL -> J: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0})
//     11100 SYSTEM: funct3[2]=1 -> Z: zext(instr[19:15]); funct3[2]=0 -> I
//     all else -> NONE, imm=0
// - Shift immediates are not trimmed; the full I form is emitted and the ALU masks shamt.
// - Sign extension always replicates instr[31] up to bit XLEN-1.
// CONFIGURATION
// - IMM_GEN_ILLEGAL_EN defined: adds port out_illegal (out,1), registered with out_*, reset 0.
//   It is 1 when fmt=NONE, and it travels through the skid alongside its beat.
// - IMM_GEN_ILLEGAL_EN undefined: port and its flops are absent; all other behaviour is identical.
// TESTING
// - addi x1,x0,-1 (0xFFF00093), XLEN=32 -> out_imm 0xFFFFFFFF, fmt 1, out_valid 1 cycle after accept.
// - sw x2,-4(x1) (0xFE20AE23) -> 0xFFFFFFFC, fmt 2. beq x0,x0,-8 (0xFE000CE3) -> 0xFFFFFFF8, fmt 3.
// - lui (0x123452B7) -> 0x12345000. XLEN=64, lui (0x800002B7) -> 0xFFFFFFFF80000000. jal (0x001000EF) -> 0x800, fmt 5.
// - csrrwi x0,0x340,5 (0x3402D073) -> 0x5, fmt 6. Word 0x00000000 -> imm 0, fmt 0, out_illegal=1 (macro on).
// - out_ready=0, three back-to-back beats -> two accepted, in_ready=0 on third; out_ready=1 -> tags out in order, none lost.
// - Flush with skid full plus in_valid -> next cycle out_valid=0, in_ready=1, no stale beat emitted.
//   reset asserted mid-stall -> all outputs return to reset values immediately (async).

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Registered RV32I/RV64I immediate generator with valid/ready handshake and a skid slot.
// Optional macro IMM_GEN_ILLEGAL_EN adds out_illegal, flagged for beats that decode to NONE.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [TAG_W-1:0] out_tag
`ifdef IMM_GEN_ILLEGAL_EN
  ,
  output logic             out_illegal
`endif
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;

  function automatic logic [2:0] dec_fmt(input logic [31:0] ins);
    logic [2:0] f;
    f = FMT_NONE;
    if (ins[1:0] == 2'b11) begin
      case (ins[6:2])
        5'b00000, 5'b00100, 5'b11001, 5'b00011: f = FMT_I;
        5'b00110: f = (XLEN == 64) ? FMT_I : FMT_NONE;
        5'b01000: f = FMT_S;
        5'b11000: f = FMT_B;
        5'b01101, 5'b00101: f = FMT_U;
        5'b11011: f = FMT_J;
        5'b11100: f = ins[14] ? FMT_Z : FMT_I;
        default:  f = FMT_NONE;
      endcase
    end
    return f;
  endfunction

  // Build the 32-bit immediate, then replicate bit 31 up to XLEN-1 (zimm has bit 31 clear).
  function automatic logic [XLEN-1:0] dec_imm(input logic [31:0] ins, input logic [2:0] f);
    logic [31:0]     v;
    logic [XLEN-1:0] r;
    case (f)
      FMT_I:   v = {{20{ins[31]}}, ins[31:20]};
      FMT_S:   v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:   v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U:   v = {ins[31:12], 12'h000};
      FMT_J:   v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      FMT_Z:   v = {27'd0, ins[19:15]};
      default: v = 32'd0;
    endcase
    r = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  logic [2:0]       w_fmt_p0;
  logic [XLEN-1:0]  w_imm_p0;
  logic             w_accept;
  logic             w_drain;
  logic             w_load_new;
  logic             w_load_skid;
  logic             w_fill_skid;
  logic             w_unused;

  logic             r_vld_p1;
  logic [XLEN-1:0]  r_imm_p1;
  logic [2:0]       r_fmt_p1;
  logic [TAG_W-1:0] r_tag_p1;
  logic             r_skid_vld_p1;
  logic [XLEN-1:0]  r_skid_imm_p1;
  logic [2:0]       r_skid_fmt_p1;
  logic [TAG_W-1:0] r_skid_tag_p1;

  // ---- p0: decode ----
  assign w_fmt_p0 = dec_fmt(in_instr);
  assign w_imm_p0 = dec_imm(in_instr, w_fmt_p0);
  assign w_unused = &{1'b0, in_instr[13:12]};

  assign in_ready    = !r_skid_vld_p1;
  assign w_accept    = in_valid && !r_skid_vld_p1;
  assign w_drain     = !r_vld_p1 || out_ready;
  assign w_load_new  = !flush && w_accept && w_drain;
  assign w_load_skid = !flush && r_skid_vld_p1 && out_ready;
  assign w_fill_skid = !flush && w_accept && !w_drain;

  // ---- p1: output register and skid slot ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p1      <= 1'b0;
      r_skid_vld_p1 <= 1'b0;
    end else if (flush) begin
      r_vld_p1      <= 1'b0;
      r_skid_vld_p1 <= 1'b0;
    end else if (r_skid_vld_p1) begin
      if (out_ready) r_skid_vld_p1 <= 1'b0;
    end else if (w_accept) begin
      if (w_drain) r_vld_p1 <= 1'b1;
      else         r_skid_vld_p1 <= 1'b1;
    end else if (out_ready) begin
      r_vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_imm_p1 <= '0;
      r_fmt_p1 <= FMT_NONE;
      r_tag_p1 <= '0;
    end else if (w_load_skid) begin
      r_imm_p1 <= r_skid_imm_p1;
      r_fmt_p1 <= r_skid_fmt_p1;
      r_tag_p1 <= r_skid_tag_p1;
    end else if (w_load_new) begin
      r_imm_p1 <= w_imm_p0;
      r_fmt_p1 <= w_fmt_p0;
      r_tag_p1 <= in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill_skid) begin
      r_skid_imm_p1 <= w_imm_p0;
      r_skid_fmt_p1 <= w_fmt_p0;
      r_skid_tag_p1 <= in_tag;
    end
  end

`ifdef IMM_GEN_ILLEGAL_EN
  logic r_ill_p1;
  logic r_skid_ill_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            r_ill_p1 <= 1'b0;
    else if (w_load_skid) r_ill_p1 <= r_skid_ill_p1;
    else if (w_load_new)  r_ill_p1 <= (w_fmt_p0 == FMT_NONE);
  end

  always_ff @(posedge clk) begin
    if (w_fill_skid) r_skid_ill_p1 <= (w_fmt_p0 == FMT_NONE);
  end

  assign out_illegal = r_ill_p1;
`endif

  assign out_valid = r_vld_p1;
  assign out_imm   = r_imm_p1;
  assign out_fmt   = r_fmt_p1;
  assign out_tag   = r_tag_p1;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus and are scored
// against a queue-based reference model; directed literals pin both the model and the DUT.
module tb_imm_gen_pipe;
  localparam int TAG_W = 16;

  logic             clk = 1'b0;
  logic             reset, flush, in_valid, out_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             in_ready32, in_ready64, out_valid32, out_valid64;
  logic [31:0]      imm32;
  logic [63:0]      imm64;
  logic [2:0]       fmt32, fmt64;
  logic [TAG_W-1:0] tag32, tag64;
`ifdef IMM_GEN_ILLEGAL_EN
  logic             ill32, ill64;
`endif

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_tag(tag32)
`ifdef IMM_GEN_ILLEGAL_EN
    , .out_illegal(ill32)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_tag(tag64)
`ifdef IMM_GEN_ILLEGAL_EN
    , .out_illegal(ill64)
`endif
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // Reference decoder: works on the full 7-bit opcode and signed integer arithmetic.
  function automatic void ref_dec(input logic [31:0] w, input int xlen,
                                  output logic [63:0] imm, output logic [2:0] fmt);
    longint s;
    logic [6:0] op;
    op  = w[6:0];
    s   = 0;
    fmt = 3'd0;
    case (op)
      7'h03, 7'h13, 7'h67, 7'h0F: begin fmt = 3'd1; s = $signed(w[31:20]); end
      7'h1B: if (xlen == 64) begin fmt = 3'd1; s = $signed(w[31:20]); end
      7'h23: begin fmt = 3'd2; s = $signed({w[31:25], w[11:7]}); end
      7'h63: begin fmt = 3'd3; s = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0}); end
      7'h37, 7'h17: begin fmt = 3'd4; s = $signed({w[31:12], 12'h000}); end
      7'h6F: begin fmt = 3'd5; s = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0}); end
      7'h73: begin
        if (w[14]) begin fmt = 3'd6; s = longint'(w[19:15]); end
        else       begin fmt = 3'd1; s = $signed(w[31:20]); end
      end
      default: ;
    endcase
    imm = (xlen == 32) ? {32'h0, s[31:0]} : s;
  endfunction

  typedef struct {
    logic [31:0]      instr;
    logic [TAG_W-1:0] tag;
  } beat_t;
  beat_t q[$];

  // Model: at most two beats in flight; flush and reset discard them.
  always @(posedge clk or posedge reset) begin
    if (reset || flush) q.delete();
    else begin
      bit acc, xf;
      acc = in_valid && (q.size() < 2);
      xf  = (q.size() > 0) && out_ready;
      if (xf) void'(q.pop_front());
      if (acc) q.push_back('{in_instr, in_tag});
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      logic [63:0] e;
      logic [2:0]  f;
      chk("in_ready32", in_ready32, q.size() < 2);
      chk("in_ready64", in_ready64, q.size() < 2);
      chk("out_valid32", out_valid32, q.size() > 0);
      chk("out_valid64", out_valid64, q.size() > 0);
      if (q.size() > 0) begin
        ref_dec(q[0].instr, 32, e, f);
        chk("imm32", {32'h0, imm32}, e);
        chk("fmt32", fmt32, f);
        chk("tag32", tag32, q[0].tag);
`ifdef IMM_GEN_ILLEGAL_EN
        chk("ill32", ill32, f == 3'd0);
`endif
        ref_dec(q[0].instr, 64, e, f);
        chk("imm64", imm64, e);
        chk("fmt64", fmt64, f);
        chk("tag64", tag64, q[0].tag);
`ifdef IMM_GEN_ILLEGAL_EN
        chk("ill64", ill64, f == 3'd0);
`endif
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the beat was taken, valid still high.
  task automatic send(input logic [31:0] ins, input logic [TAG_W-1:0] tg);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    in_valid = 1'b1;
    in_instr = ins;
    in_tag   = tg;
    while (!acc && n < 50) begin
      acc = in_ready32;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  typedef struct {
    logic [31:0] instr;
    int          xlen;
    logic [63:0] imm;
    logic [2:0]  fmt;
  } pin_t;

  pin_t pins[$] = '{
    '{32'hFFF00093, 32, 64'h00000000FFFFFFFF, 3'd1},
    '{32'hFE20AE23, 32, 64'h00000000FFFFFFFC, 3'd2},
    '{32'hFE000CE3, 32, 64'h00000000FFFFFFF8, 3'd3},
    '{32'h123452B7, 32, 64'h0000000012345000, 3'd4},
    '{32'h800002B7, 64, 64'hFFFFFFFF80000000, 3'd4},
    '{32'h001000EF, 32, 64'h0000000000000800, 3'd5},
    '{32'h3402D073, 64, 64'h0000000000000005, 3'd6},
    '{32'h00000000, 32, 64'h0000000000000000, 3'd0},
    '{32'hFFF0809B, 32, 64'h0000000000000000, 3'd0},
    '{32'hFFF0809B, 64, 64'hFFFFFFFFFFFFFFFF, 3'd1},
    '{32'h34029073, 32, 64'h0000000000000340, 3'd1},
    '{32'h0FF0000F, 64, 64'h00000000000000FF, 3'd1},
    '{32'hFFF00090, 32, 64'h0000000000000000, 3'd0}
  };

  logic [31:0] stream[$] = '{32'hFE20AE23, 32'hFE000CE3, 32'h123452B7, 32'hFFF0809B,
                             32'h34029073, 32'h0FF0000F, 32'hFFC080E7, 32'hFFFFF297,
                             32'h00000033, 32'hFFF00090};

  initial begin
    logic [63:0] e;
    logic [2:0]  f;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = 32'h0; in_tag = '0;
    @(posedge clk); #2;
    chk("rst_out_valid", out_valid32, 1'b0);
    chk("rst_in_ready", in_ready32, 1'b1);
    chk("rst_imm64", imm64, 64'h0);
    chk("rst_fmt", fmt32, 3'd0);
    chk("rst_tag", tag64, '0);

    foreach (pins[i]) begin
      ref_dec(pins[i].instr, pins[i].xlen, e, f);
      chk($sformatf("pin_imm_%0d", i), e, pins[i].imm);
      chk($sformatf("pin_fmt_%0d", i), f, pins[i].fmt);
    end

    reset = 1'b0;
    @(posedge clk); #1;

    send(32'hFFF00093, 1);
    chk("addi_valid", out_valid32, 1'b1);
    chk("addi_imm32", imm32, 32'hFFFFFFFF);
    chk("addi_fmt", fmt32, 3'd1);
    send(32'h800002B7, 2);
    chk("lui64_imm", imm64, 64'hFFFFFFFF80000000);
    send(32'h001000EF, 3);
    chk("jal_imm32", imm32, 32'h00000800);
    chk("jal_fmt", fmt32, 3'd5);
    send(32'h3402D073, 4);
    chk("csrrwi_imm", imm32, 32'h5);
    chk("csrrwi_fmt", fmt32, 3'd6);
    send(32'h00000000, 5);
    chk("zero_fmt", fmt32, 3'd0);
`ifdef IMM_GEN_ILLEGAL_EN
    chk("zero_illegal", ill32, 1'b1);
`endif
    foreach (stream[i]) send(stream[i], TAG_W'(16 + i));
    idle(3);

    // Backpressure: two beats taken, third refused until the consumer drains.
    out_ready = 1'b0;
    send(32'hFFF00093, 100);
    send(32'h00A00113, 101);
    in_instr = 32'h123452B7; in_tag = 102;
    chk("bp_in_ready", in_ready32, 1'b0);
    @(posedge clk); #1;
    chk("bp_hold_tag", tag32, 100);
    chk("bp_still_full", in_ready64, 1'b0);
    out_ready = 1'b1;
    send(32'h123452B7, 102);
    idle(4);

    // Flush with skid full and a beat on the input.
    out_ready = 1'b0;
    send(32'hFFF00093, 200);
    send(32'hFE20AE23, 201);
    in_instr = 32'hFE000CE3; in_tag = 202; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid32, 1'b0);
    chk("flush_in_ready", in_ready32, 1'b1);
    out_ready = 1'b1;
    idle(3);
    chk("flush_no_stale", out_valid64, 1'b0);

    // Flush beats a simultaneous accept into an empty pipe.
    in_valid = 1'b1; in_instr = 32'h001000EF; in_tag = 210; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_vs_accept", out_valid32, 1'b0);
    idle(2);

    // Asynchronous reset in the middle of a stall.
    out_ready = 1'b0;
    send(32'hFFF00093, 300);
    send(32'h800002B7, 301);
    in_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    chk("arst_out_valid", out_valid64, 1'b0);
    chk("arst_in_ready", in_ready32, 1'b1);
    chk("arst_imm64", imm64, 64'h0);
    chk("arst_tag", tag32, '0);
    #4 reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(32'h3402D073, 400);
    idle(4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
